// File: rtl/byte_pair_packer_pkg.sv
// Shared definitions for the byte pair packer: lane-enable codes common with the
// byte-enabled register stage, and the packer FSM state encoding.
package byte_pair_packer_pkg;

    localparam logic [1:0] BE_NONE = 2'b00;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_FULL = 2'b11;

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } packState_t;

endpackage

// File: rtl/byte_pair_packer_pack_out_reg.sv
// Single-entry valid/ready holding register for a packed word and its byte-enable.
// A new word may load in the same cycle the current one is consumed.
module pack_out_reg
    import byte_pair_packer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic [15:0] i_data,
    input  logic [1:0]  i_byteena,
    input  logic        i_ready,
    output logic [15:0] o_data,
    output logic [1:0]  o_byteena,
    output logic        o_valid,
    output logic        o_slotFree
);

    logic [15:0] r_data;
    logic [1:0]  r_byteena;
    logic        r_valid;

    // Data is left untouched on consumption; only valid and the lane enable clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data    <= 16'h0000;
            r_byteena <= BE_NONE;
            r_valid   <= 1'b0;
        end else if (i_load) begin
            r_data    <= i_data;
            r_byteena <= i_byteena;
            r_valid   <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_byteena <= BE_NONE;
            r_valid   <= 1'b0;
        end
    end

    assign o_data     = r_data;
    assign o_byteena  = r_byteena;
    assign o_valid    = r_valid;
    assign o_slotFree = !r_valid || i_ready;

endmodule

// File: rtl/byte_pair_packer.sv
// Packs a valid/ready byte stream into 16-bit words with byte-enables; a lone
// trailing byte is emitted as a low-lane word on flush or after an idle timeout.
module byte_pair_packer
    import byte_pair_packer_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic [15:0] out_data,
    output logic [1:0]  out_byteena,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        pending
);

    // CNT_W must be wide enough to hold TIMEOUT itself.
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    packState_t       r_state;
    packState_t       w_stateNext;
    logic [7:0]       r_lo;
    logic [7:0]       w_loNext;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic             r_flushReq;
    logic             w_flushReqNext;

    logic             w_slotFree;
    logic             w_accept;
    logic             w_timeoutHit;
    logic             w_load;
    logic [15:0]      w_loadData;
    logic [1:0]       w_loadBe;

    assign in_ready     = (r_state == EMPTY) || w_slotFree;
    assign w_accept     = in_valid && in_ready;
    assign w_timeoutHit = (TIMEOUT != 0) && (r_state == HALF) && (r_cnt == TIMEOUT_CNT);
    assign pending      = (r_state == HALF);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= EMPTY;
            r_lo       <= 8'h00;
            r_cnt      <= '0;
            r_flushReq <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_lo       <= w_loNext;
            r_cnt      <= w_cntNext;
            r_flushReq <= w_flushReqNext;
        end
    end

    // A completing byte always wins over a flush or timeout in the same cycle.
    always_comb begin
        w_stateNext    = r_state;
        w_loNext       = r_lo;
        w_cntNext      = r_cnt;
        w_flushReqNext = r_flushReq;
        w_load         = 1'b0;
        w_loadData     = {8'h00, r_lo};
        w_loadBe       = BE_LO;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_loNext       = in_byte;
                    w_cntNext      = '0;
                    w_flushReqNext = 1'b0;
                    w_stateNext    = HALF;
                end
            end
            HALF: begin
                if (w_accept) begin
                    w_load         = 1'b1;
                    w_loadData     = {in_byte, r_lo};
                    w_loadBe       = BE_FULL;
                    w_flushReqNext = 1'b0;
                    w_stateNext    = EMPTY;
                end else if ((flush || r_flushReq || w_timeoutHit) && w_slotFree) begin
                    w_load         = 1'b1;
                    w_flushReqNext = 1'b0;
                    w_stateNext    = EMPTY;
                end else begin
                    if (r_cnt != TIMEOUT_CNT) begin
                        w_cntNext = r_cnt + 1'b1;
                    end
                    w_flushReqNext = r_flushReq || flush;
                end
            end
            default: w_stateNext = EMPTY;
        endcase
    end

    pack_out_reg u_outReg (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_data     (w_loadData),
        .i_byteena  (w_loadBe),
        .i_ready    (out_ready),
        .o_data     (out_data),
        .o_byteena  (out_byteena),
        .o_valid    (out_valid),
        .o_slotFree (w_slotFree)
    );

endmodule
